wb_stream_uart: RTL and testbench

Parametrised Wishbone slave with a character-stream UART register model. It has two registers (data and control), separate TX and RX FIFOs of configurable depth and width, a level-sensitive interrupt, sticky status flags, and a valid/ready byte-stream port toward a serialiser, a JTAG bridge or a simulation host. It sits on the peripheral Wishbone bus of a tile. Software written for the Altera JTAG-UART register layout runs on it unchanged on any FPGA vendor and in simulation.

---
 rtl/wb_stream_uart_pkg.sv | 24 ++
 rtl/wb_uart_sync_fifo.sv | 59 +++++
 rtl/wb_stream_uart.sv | 155 +++++++++++++++
 tb/tb_wb_stream_uart.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_uart_pkg.sv
// Shared register map for the Wishbone character-stream UART:
// addresses, bit positions and bus FSM states.
package wb_stream_uart_pkg;

   localparam logic DATA_ADR = 1'b0;
   localparam logic CTRL_ADR = 1'b1;

   localparam int RE_BIT     = 0;
   localparam int WE_BIT     = 1;
   localparam int RI_BIT     = 8;
   localparam int WI_BIT     = 9;
   localparam int AC_BIT     = 10;
   localparam int OV_BIT     = 11;
   localparam int RVALID_BIT = 15;

   localparam int RAVAIL_LSB = 16;
   localparam int WSPACE_LSB = 16;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_t;

endpackage

// File: rtl/wb_uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on a full FIFO frees the slot
// for a same-cycle push, a push on an empty FIFO is never bypassed to a pop.
module wb_uart_sync_fifo
   import wb_stream_uart_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int W     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; only the pointers and
   // count define what is valid, which lets the array map onto block RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_stream_uart.sv
// Wishbone slave exposing a JTAG-UART compatible DATA/CONTROL register pair
// over TX/RX FIFOs, with a valid/ready character stream on the far side.
module wb_stream_uart
   import wb_stream_uart_pkg::*;
#(
   parameter int TX_FIFO_DEPTH = 64,
   parameter int RX_FIFO_DEPTH = 64,
   parameter int CHAR_W        = 8,
   parameter int WI_THRESH     = TX_FIFO_DEPTH / 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       s_dat_i,
   input  logic [3:0]        s_sel_i,
   input  logic              s_addr_i,
   input  logic [2:0]        s_cti_i,
   input  logic              s_stb_i,
   input  logic              s_cyc_i,
   input  logic              s_we_i,
   output logic [31:0]       s_dat_o,
   output logic              s_ack_o,
   output logic              irq,
   output logic [CHAR_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [CHAR_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready
);

   localparam int TX_CW = $clog2(TX_FIFO_DEPTH + 1);
   localparam int RX_CW = $clog2(RX_FIFO_DEPTH + 1);

   bus_state_t        state;
   bus_state_t        state_next;
   logic              take;

   logic              tx_push, tx_pop, tx_full, tx_empty, tx_drop;
   logic [TX_CW-1:0]  tx_count;
   logic [TX_CW-1:0]  tx_free;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [RX_CW-1:0]  rx_count;
   logic [CHAR_W-1:0] rx_head;

   logic              rx_irq_en, tx_irq_en, tx_activity, tx_overflow;
   logic              rx_irq, tx_irq;
   logic              ctrl_wr;
   logic [31:0]       rd_data;

   // Byte lanes and burst hints are meaningless for these two registers.
   logic              unused_bus_bits;
   assign unused_bus_bits = ^{s_sel_i, s_cti_i, s_dat_i};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= BUS_IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      take       = 1'b0;
      case (state)
         BUS_IDLE: begin
            if (s_stb_i && s_cyc_i) begin
               take       = 1'b1;
               state_next = BUS_ACK;
            end
         end
         BUS_ACK:  state_next = BUS_IDLE;
         default:  state_next = BUS_IDLE;
      endcase
   end

   assign s_ack_o = (state == BUS_ACK);

   assign tx_push  = take & s_we_i & (s_addr_i == DATA_ADR);
   assign tx_pop   = tx_valid & tx_ready;
   assign tx_drop  = tx_push & tx_full & ~tx_pop;
   assign tx_valid = ~tx_empty;
   assign tx_free  = TX_CW'(TX_FIFO_DEPTH) - tx_count;

   assign rx_ready = ~rx_full;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = take & ~s_we_i & (s_addr_i == DATA_ADR);

   assign ctrl_wr  = take & s_we_i & (s_addr_i == CTRL_ADR);

   wb_uart_sync_fifo #(.DEPTH(TX_FIFO_DEPTH), .W(CHAR_W)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (s_dat_i[CHAR_W-1:0]),
      .dout  (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   wb_uart_sync_fifo #(.DEPTH(RX_FIFO_DEPTH), .W(CHAR_W)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_data),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   assign rx_irq = rx_irq_en & ~rx_empty;
   assign tx_irq = tx_irq_en & (tx_free >= TX_CW'(WI_THRESH));
   assign irq    = rx_irq | tx_irq;

   always_comb begin
      rd_data = '0;
      if (s_addr_i == CTRL_ADR) begin
         rd_data[WSPACE_LSB +: 16] = 16'(tx_free);
         rd_data[OV_BIT]           = tx_overflow;
         rd_data[AC_BIT]           = tx_activity;
         rd_data[WI_BIT]           = tx_irq;
         rd_data[RI_BIT]           = rx_irq;
         rd_data[WE_BIT]           = tx_irq_en;
         rd_data[RE_BIT]           = rx_irq_en;
      end else if (!rx_empty) begin
         // RAVAIL reports what is left once this read's pop has happened.
         rd_data[RAVAIL_LSB +: 16] = 16'(rx_count - RX_CW'(1));
         rd_data[RVALID_BIT]       = 1'b1;
         rd_data[CHAR_W-1:0]       = rx_head;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_dat_o     <= '0;
         rx_irq_en   <= 1'b0;
         tx_irq_en   <= 1'b0;
         tx_activity <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         s_dat_o <= (take && !s_we_i) ? rd_data : '0;
         if (ctrl_wr) begin
            rx_irq_en <= s_dat_i[RE_BIT];
            tx_irq_en <= s_dat_i[WE_BIT];
         end
         // Sticky flags: a set event in the same cycle as a clear wins.
         tx_activity <= tx_pop  | (tx_activity & ~(ctrl_wr & s_dat_i[AC_BIT]));
         tx_overflow <= tx_drop | (tx_overflow & ~(ctrl_wr & s_dat_i[OV_BIT]));
      end
   end

endmodule

// File: tb/tb_wb_stream_uart.sv
// Directed bench for wb_stream_uart: register map, stream ordering, flags,
// interrupts, FIFO boundaries and asynchronous reset.
`timescale 1ns/1ps
module tb_wb_stream_uart;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] s_dat_i = '0;
   logic [3:0]  s_sel_i = 4'hF;
   logic        s_addr_i = 1'b0;
   logic [2:0]  s_cti_i = '0;
   logic        s_stb_i = 1'b0;
   logic        s_cyc_i = 1'b0;
   logic        s_we_i = 1'b0;
   logic [31:0] s_dat_o;
   logic        s_ack_o;
   logic        irq;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_stream_uart dut (
      .clk      (clk),
      .reset    (reset),
      .s_dat_i  (s_dat_i),
      .s_sel_i  (s_sel_i),
      .s_addr_i (s_addr_i),
      .s_cti_i  (s_cti_i),
      .s_stb_i  (s_stb_i),
      .s_cyc_i  (s_cyc_i),
      .s_we_i   (s_we_i),
      .s_dat_o  (s_dat_o),
      .s_ack_o  (s_ack_o),
      .irq      (irq),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   // Bus transfer; entered and left 1ns after a rising edge with the FSM idle.
   task automatic wb_xfer(input logic we, input logic adr, input logic [31:0] wdat,
                          output logic [31:0] rdat);
      s_stb_i = 1'b1; s_cyc_i = 1'b1; s_we_i = we; s_addr_i = adr; s_dat_i = wdat;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (s_ack_o) break;
      end
      checks++;
      if (s_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL ack_timeout: s_ack_o=%b required 1", s_ack_o);
      end
      rdat = s_dat_o;
      s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0; s_dat_i = '0;
      @(posedge clk); #1;
   endtask

   task automatic wb_write(input logic adr, input logic [31:0] wdat);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, wdat, dummy);
   endtask

   task automatic rx_push(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      #2;
      checks++;
      if ({s_ack_o, s_dat_o, irq, tx_valid, rx_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b dat=%h irq=%b tx_valid=%b rx_ready=%b required 0/0/0/0/1",
                  s_ack_o, s_dat_o, irq, tx_valid, rx_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      wb_xfer(1'b0, 1'b1, '0, rd);
      checks++;
      if (rd !== 32'h0040_0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %h required 00400000", rd);
      end
   endtask

   task automatic test_tx_stream;
      logic [31:0] rd;
      logic [7:0]  exp_seq [3];
      exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h43;
      tx_ready = 1'b0;
      wb_write(1'b0, 32'h41);
      wb_write(1'b0, 32'h42);
      wb_write(1'b0, 32'h43);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
            errors++;
            $display("FAIL tx_order[%0d]: valid=%b data=%h required 1/%h", i, tx_valid, tx_data, exp_seq[i]);
         end
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL tx_drained: tx_valid=%b required 0", tx_valid);
      end
      wb_xfer(1'b0, 1'b1, '0, rd);
      checks++;
      if (rd !== 32'h0040_0400) begin
         errors++;
         $display("FAIL ac_set: got %h required 00400400", rd);
      end
      wb_write(1'b1, 32'h400);
      wb_xfer(1'b0, 1'b1, '0, rd);
      checks++;
      if (rd !== 32'h0040_0000) begin
         errors++;
         $display("FAIL ac_clear: got %h required 00400000", rd);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] rd;
      tx_ready = 1'b0;
      for (int i = 0; i < 64; i++) wb_write(1'b0, 32'(i));
      wb_write(1'b0, 32'h5A);
      wb_xfer(1'b0, 1'b1, '0, rd);
      checks++;
      if (rd !== 32'h0000_0800) begin
         errors++;
         $display("FAIL ov_full_ctrl: got %h required 00000800", rd);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
            errors++;
            $display("FAIL drain[%0d]: valid=%b data=%h required 1/%h", i, tx_valid, tx_data, 8'(i));
         end
         @(posedge clk); #1;
      end
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL dropped_char_emitted: tx_valid=%b data=%h required valid 0", tx_valid, tx_data);
      end
      tx_ready = 1'b0;
      wb_write(1'b1, 32'h0C00);
      wb_xfer(1'b0, 1'b1, '0, rd);
      checks++;
      if (rd !== 32'h0040_0000) begin
         errors++;
         $display("FAIL ov_clear: got %h required 00400000", rd);
      end
   endtask

   task automatic test_rx_read;
      logic [31:0] rd;
      logic [31:0] exp_rd [4];
      exp_rd[0] = 32'h0002_8010; exp_rd[1] = 32'h0001_8011;
      exp_rd[2] = 32'h0000_8012; exp_rd[3] = 32'h0000_0000;
      rx_push(8'h10);
      rx_push(8'h11);
      rx_push(8'h12);
      for (int i = 0; i < 4; i++) begin
         wb_xfer(1'b0, 1'b0, '0, rd);
         checks++;
         if (rd !== exp_rd[i]) begin
            errors++;
            $display("FAIL rx_read[%0d]: got %h required %h", i, rd, exp_rd[i]);
         end
      end
   endtask

   task automatic test_irq;
      logic [31:0] rd;
      wb_write(1'b1, 32'h1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_re_empty: irq=%b required 0", irq);
      end
      rx_push(8'h77);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_rx_char: irq=%b required 1", irq);
      end
      wb_xfer(1'b0, 1'b0, '0, rd);
      checks++;
      if (rd !== 32'h0000_8077 || irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_after_read: data=%h irq=%b required 00008077/0", rd, irq);
      end
      wb_write(1'b1, 32'h3);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_we_tx_empty: irq=%b required 1", irq);
      end
      wb_write(1'b1, 32'h0);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_disabled: irq=%b required 0", irq);
      end
   endtask

   task automatic test_rx_simultaneous;
      logic [31:0] rd;
      logic [31:0] exp;
      for (int i = 0; i < 63; i++) rx_push(8'(i));
      // pop by the bus and push by the stream land on the same edge
      s_stb_i = 1'b1; s_cyc_i = 1'b1; s_we_i = 1'b0; s_addr_i = 1'b0;
      rx_valid = 1'b1; rx_data = 8'hEE;
      @(posedge clk); #1;
      rx_valid = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
      checks++;
      if (s_ack_o !== 1'b1 || s_dat_o[15:0] !== 16'h8000) begin
         errors++;
         $display("FAIL sim_pop: ack=%b data=%h required 1/xxxx8000", s_ack_o, s_dat_o);
      end
      @(posedge clk); #1;
      checks++;
      if (rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL sim_count63: rx_ready=%b required 1", rx_ready);
      end
      rx_push(8'hEF);
      checks++;
      if (rx_ready !== 1'b0) begin
         errors++;
         $display("FAIL rx_full64: rx_ready=%b required 0", rx_ready);
      end
      for (int k = 0; k < 64; k++) begin
         wb_xfer(1'b0, 1'b0, '0, rd);
         exp = {16'(63 - k), 16'h8000};
         exp[7:0] = (k < 62) ? 8'(k + 1) : ((k == 62) ? 8'hEE : 8'hEF);
         checks++;
         if (rd !== exp) begin
            errors++;
            $display("FAIL rx_drain[%0d]: got %h required %h", k, rd, exp);
         end
      end
   endtask

   task automatic test_reset_mid_ack;
      logic [31:0] rd;
      tx_ready = 1'b0;
      wb_write(1'b0, 32'h33);
      rx_push(8'h44);
      s_stb_i = 1'b1; s_cyc_i = 1'b1; s_we_i = 1'b0; s_addr_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (s_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_ack_taken: ack=%b required 1", s_ack_o);
      end
      reset = 1'b1;
      #1;
      s_stb_i = 1'b0; s_cyc_i = 1'b0;
      checks++;
      if ({s_ack_o, s_dat_o, tx_valid, rx_ready, irq} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_async: ack=%b dat=%h tx_valid=%b rx_ready=%b irq=%b required 0/0/0/1/0",
                  s_ack_o, s_dat_o, tx_valid, rx_ready, irq);
      end
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      wb_xfer(1'b0, 1'b0, '0, rd);
      checks++;
      if (rd !== 32'h0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL flushed: data=%h tx_valid=%b required 00000000/0", rd, tx_valid);
      end
      wb_xfer(1'b0, 1'b1, '0, rd);
      checks++;
      if (rd !== 32'h0040_0000) begin
         errors++;
         $display("FAIL post_reset_ctrl: got %h required 00400000", rd);
      end
   endtask

   initial begin
      test_reset();
      test_tx_stream();
      test_overflow();
      test_rx_read();
      test_irq();
      test_rx_simultaneous();
      test_reset_mid_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
